// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: PC-indexed table of saturating counters with B-type/JAL decode.
// The table self-initialises after reset and is trained by execute-stage feedback.
module branch_predictor_bimodal #(
  parameter int unsigned INDEX_BITS   = 10,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic [31:0]           ins_data_in,
  input  logic [31:0]           pc_addr_in,
  input  logic                  feedback_enable_in,
  input  logic [INDEX_BITS-1:0] feedback_index_in,
  input  logic                  feedback_taken_in,
  output logic                  ready_out,
  output logic                  taken_pred_out,
  output logic                  pc_branch_sel_out,
  output logic [31:0]           pred_pc_out,
  output logic [INDEX_BITS-1:0] pred_index_out
);

  localparam int unsigned Depth = 2 ** INDEX_BITS;

  typedef logic [COUNTER_BITS-1:0] ctr_t;

  localparam ctr_t CtrMax  = '1;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam ctr_t CtrInit = CtrMax >> 1;

  typedef enum logic {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  ctr_t                  table_q [Depth];

  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  ctr_t                  wr_val;
  ctr_t                  fb_ctr;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_val  = CtrInit;
    fb_ctr  = table_q[feedback_index_in];
    unique case (state_q)
      StInit: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (feedback_enable_in) begin
          wr_en  = 1'b1;
          wr_idx = feedback_index_in;
          if (feedback_taken_in) begin
            wr_val = (fb_ctr == CtrMax) ? fb_ctr : fb_ctr + ctr_t'(1);
          end else begin
            wr_val = (fb_ctr == '0) ? fb_ctr : fb_ctr - ctr_t'(1);
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Table has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clock_in) begin
    if (wr_en) begin
      table_q[wr_idx] <= wr_val;
    end
  end

  logic                  is_branch;
  logic                  is_jal;
  logic [31:0]           b_imm;
  logic [31:0]           j_imm;
  logic [INDEX_BITS-1:0] lookup_idx;
  ctr_t                  lookup_ctr;
  logic                  ready;
  logic                  taken;
  logic                  sel;

  always_comb begin
    is_branch  = ins_data_in[6:0] == 7'b1100011;
    is_jal     = ins_data_in[6:0] == 7'b1101111;
    b_imm      = {{19{ins_data_in[31]}}, ins_data_in[31], ins_data_in[7],
                  ins_data_in[30:25], ins_data_in[11:8], 1'b0};
    j_imm      = {{11{ins_data_in[31]}}, ins_data_in[31], ins_data_in[19:12],
                  ins_data_in[20], ins_data_in[30:21], 1'b0};
    lookup_idx = pc_addr_in[INDEX_BITS+1:2];
    lookup_ctr = table_q[lookup_idx];
    ready      = state_q == StRun;
    taken      = ready & (is_jal | (is_branch & lookup_ctr[COUNTER_BITS-1]));
    sel        = ready & taken;
  end

  assign ready_out         = ready;
  assign taken_pred_out    = taken;
  assign pc_branch_sel_out = sel;
  assign pred_pc_out       = pc_addr_in + (sel ? (is_jal ? j_imm : b_imm) : 32'd4);
  assign pred_index_out    = lookup_idx;

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Directed bench for branch_predictor_bimodal: default instance plus a small 16-entry, 3-bit one.
module tb_branch_predictor_bimodal;

  localparam logic [31:0] Beq8  = 32'h00000463;
  localparam logic [31:0] BeqM4 = 32'hFE000EE3;
  localparam logic [31:0] JalM8 = 32'hFF9FF06F;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fb_en, fb_tk;
  logic [31:0] ins, pc;
  logic [9:0]  fb_idx;
  logic        ready, taken, sel;
  logic [31:0] ppc;
  logic [9:0]  pidx;

  logic        rst2_n, fb2_en, fb2_tk;
  logic [31:0] ins2, pc2;
  logic [3:0]  fb2_idx;
  logic        ready2, taken2, sel2;
  logic [31:0] ppc2;
  logic [3:0]  pidx2;

  int total = 0;
  int bad   = 0;

  branch_predictor_bimodal dut (
    .clock_in          (clk),
    .reset_n_in        (rst_n),
    .ins_data_in       (ins),
    .pc_addr_in        (pc),
    .feedback_enable_in(fb_en),
    .feedback_index_in (fb_idx),
    .feedback_taken_in (fb_tk),
    .ready_out         (ready),
    .taken_pred_out    (taken),
    .pc_branch_sel_out (sel),
    .pred_pc_out       (ppc),
    .pred_index_out    (pidx)
  );

  branch_predictor_bimodal #(.INDEX_BITS(4), .COUNTER_BITS(3)) dut2 (
    .clock_in          (clk),
    .reset_n_in        (rst2_n),
    .ins_data_in       (ins2),
    .pc_addr_in        (pc2),
    .feedback_enable_in(fb2_en),
    .feedback_index_in (fb2_idx),
    .feedback_taken_in (fb2_tk),
    .ready_out         (ready2),
    .taken_pred_out    (taken2),
    .pc_branch_sel_out (sel2),
    .pred_pc_out       (ppc2),
    .pred_index_out    (pidx2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fb(input logic [9:0] idx, input logic tk, input int n);
    fb_en  = 1'b1;
    fb_idx = idx;
    fb_tk  = tk;
    repeat (n) tick();
    fb_en = 1'b0;
    #1;
  endtask

  task automatic lookup(input logic [31:0] i, input logic [31:0] p);
    ins = i;
    pc  = p;
    #1;
  endtask

  // Counts DEPTH edges from reset release; ready must rise on the last one only.
  task automatic test_init_seq(input string name);
    int early = 0;
    for (int i = 1; i < 1024; i++) begin
      tick();
      if (ready !== 1'b0) early++;
    end
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL %s_early_ready: got %0d early edges, want 0", name, early);
    end
    tick();
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_1024: got %b want 1", name, ready);
    end
  endtask

  task automatic test_reset();
    fb_en = 1'b0; fb_idx = '0; fb_tk = 1'b0;
    rst_n = 1'b0;
    lookup(JalM8, 32'h100);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL rst_taken: got %b want 0", taken); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel: got %b want 0", sel); end
    total++;
    if (ppc !== 32'h104) begin bad++; $display("FAIL rst_ppc: got %h want 00000104", ppc); end
    total++;
    if (pidx !== 10'h40) begin bad++; $display("FAIL rst_pidx: got %h want 040", pidx); end
    tick();
    tick();
    rst_n = 1'b1;
    test_init_seq("init");
    lookup(Beq8, 32'h100);
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL init_taken: got %b want 0", taken); end
    total++;
    if (ppc !== 32'h104) begin bad++; $display("FAIL init_ppc: got %h want 00000104", ppc); end
  endtask

  task automatic test_training();
    lookup(Beq8, 32'h100);
    fb(10'h40, 1'b1, 2);
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL train_taken: got %b want 1", taken); end
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL train_sel: got %b want 1", sel); end
    total++;
    if (ppc !== 32'h108) begin bad++; $display("FAIL train_ppc: got %h want 00000108", ppc); end
    fb(10'h40, 1'b1, 1);
    fb(10'h40, 1'b0, 1);
    total++;
    if (taken !== 1'b1) begin bad++; $display("FAIL train_sat3_then_dec: got %b want 1", taken); end
    fb(10'h40, 1'b0, 1);
    total++;
    if (taken !== 1'b0) begin bad++; $display("FAIL train_back_to_1: got %b want 0", taken); end
    total++;
    if (ppc !== 32'h104) begin bad++; $display("FAIL train_nt_ppc: got %h want 00000104", ppc); end
  endtask

  task automatic test_immediates();
    lookup(JalM8, 32'h10);
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL jal_sel: got %b want 1", sel); end
    total++;
    if (ppc !== 32'h8) begin bad++; $display("FAIL jal_ppc: got %h want 00000008", ppc); end
    tick();
    tick();
    lookup(Beq8, 32'h10);
    total++;
    if (taken !== 1'b0) begin bad++; $display("FAIL jal_no_train: got %b want 0", taken); end
    lookup(32'h00000013, 32'h100);
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL nop_sel: got %b want 0", sel); end
    fb(10'h000, 1'b1, 2);
    lookup(BeqM4, 32'h0);
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL back_sel: got %b want 1", sel); end
    total++;
    if (ppc !== 32'hFFFFFFFC) begin bad++; $display("FAIL back_ppc: got %h want fffffffc", ppc); end
  endtask

  task automatic test_saturation_collision();
    lookup(Beq8, 32'h40);
    for (int i = 0; i < 5; i++) begin
      fb(10'h010, 1'b0, 1);
      total++;
      if (taken !== 1'b0) begin bad++; $display("FAIL sat0_dec%0d: got %b want 0", i, taken); end
    end
    fb(10'h010, 1'b1, 1);
    total++;
    if (taken !== 1'b0) begin bad++; $display("FAIL sat0_inc1: got %b want 0", taken); end
    fb(10'h010, 1'b1, 1);
    total++;
    if (taken !== 1'b1) begin bad++; $display("FAIL sat0_inc2: got %b want 1", taken); end
    // Lookup and taken feedback to index 0x20 in the same cycle.
    lookup(Beq8, 32'h80);
    fb_en = 1'b1; fb_idx = 10'h020; fb_tk = 1'b1;
    #1;
    total++;
    if (taken !== 1'b0) begin bad++; $display("FAIL coll_old: got %b want 0", taken); end
    tick();
    fb_en = 1'b0;
    #1;
    total++;
    if (taken !== 1'b1) begin bad++; $display("FAIL coll_new: got %b want 1", taken); end
  endtask

  task automatic test_reset_midop();
    lookup(Beq8, 32'h100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fb_en = 1'b1; fb_idx = 10'h040; fb_tk = 1'b1;
    repeat (500) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL midinit_ready: got %b want 0", ready); end
    tick();
    rst_n = 1'b1;
    test_init_seq("reinit1");
    fb_en = 1'b0;
    #1;
    total++;
    if (taken !== 1'b0) begin bad++; $display("FAIL init_fb_ignored: got %b want 0", taken); end
    fb(10'h040, 1'b1, 1);
    total++;
    if (taken !== 1'b1) begin bad++; $display("FAIL reinit_val01: got %b want 1", taken); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL run_rst_ready: got %b want 0", ready); end
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL run_rst_sel: got %b want 0", sel); end
    total++;
    if (ppc !== 32'h104) begin bad++; $display("FAIL run_rst_ppc: got %h want 00000104", ppc); end
    tick();
    rst_n = 1'b1;
    test_init_seq("reinit2");
    total++;
    if (taken !== 1'b0) begin bad++; $display("FAIL reinit2_val: got %b want 0", taken); end
  endtask

  task automatic test_param();
    int early = 0;
    ins2 = Beq8; pc2 = 32'h0; fb2_en = 1'b0; fb2_idx = '0; fb2_tk = 1'b1;
    rst2_n = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (ready2 !== 1'b0) early++;
    end
    total++;
    if (early !== 0) begin bad++; $display("FAIL p_early_ready: got %0d want 0", early); end
    tick();
    total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL p_ready16: got %b want 1", ready2); end
    total++; if (taken2 !== 1'b0) begin bad++; $display("FAIL p_init3: got %b want 0", taken2); end
    fb2_en = 1'b1;
    tick();
    #1;
    total++; if (taken2 !== 1'b1) begin bad++; $display("FAIL p_inc4: got %b want 1", taken2); end
    repeat (4) tick();
    fb2_tk = 1'b0;
    repeat (3) tick();
    #1;
    total++; if (taken2 !== 1'b1) begin bad++; $display("FAIL p_sat7_dec3: got %b want 1", taken2); end
    tick();
    fb2_en = 1'b0;
    #1;
    total++; if (taken2 !== 1'b0) begin bad++; $display("FAIL p_dec_to3: got %b want 0", taken2); end
    fb2_en = 1'b1; fb2_tk = 1'b1;
    tick();
    fb2_en = 1'b0;
    pc2 = 32'h40;
    #1;
    total++; if (pidx2 !== 4'h0) begin bad++; $display("FAIL p_alias_idx: got %h want 0", pidx2); end
    total++; if (taken2 !== 1'b1) begin bad++; $display("FAIL p_alias_taken: got %b want 1", taken2); end
    total++;
    if (ppc2 !== 32'h48) begin bad++; $display("FAIL p_alias_ppc: got %h want 00000048", ppc2); end
  endtask

  initial begin
    rst2_n = 1'b0; ins2 = '0; pc2 = '0; fb2_en = 1'b0; fb2_idx = '0; fb2_tk = 1'b0;
    test_reset();
    test_training();
    test_immediates();
    test_saturation_collision();
    test_reset_midop();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bimodal.md
Name: branch_predictor_bimodal

Overview:
- Parametrised bimodal branch predictor for the IFU fetch stage; successor to the fixed always-taken predictor.
- Holds a table of saturating counters indexed by PC, decodes RISC-V conditional branches (B-type) and JAL, and computes the predicted next PC.
- Trained by execute-stage feedback.
- Drives the PC-source mux select and the predicted PC.

Parameters:
INDEX_BITS, 10, log2 of table depth; DEPTH = 2**INDEX_BITS entries; lookup index = pc_addr_in[INDEX_BITS+1:2]
COUNTER_BITS, 2, width of each saturating counter (>=1); prediction = counter MSB

Ports:
clock_in  input  1  system clock, rising edge
reset_n_in  input  1  asynchronous active-low reset
ins_data_in  input  32  fetched instruction
pc_addr_in  input  32  PC of ins_data_in
feedback_enable_in  input  1  execute stage reports a resolved conditional branch this cycle
feedback_index_in  input  INDEX_BITS  table index of resolved branch (pred_index_out carried down pipeline)
feedback_taken_in  input  1  actual outcome: 1 = taken
ready_out  output  1  table initialised; predictions valid
taken_pred_out  output  1  predicted taken
pc_branch_sel_out  output  1  1 = PC mux selects pred_pc_out
pred_pc_out  output  32  predicted next PC
pred_index_out  output  INDEX_BITS  lookup index for current PC

Behaviour:
- Clock and reset: one clock, clock_in. reset_n_in is asynchronous and active-low.
- Reset (asserted at any time, including mid-init or mid-update):
  - state=INIT, init pointer=0, ready_out=0.
  - Table contents are not reset directly.
- FSM INIT:
  - Each rising edge writes entry[pointer] = 2**(COUNTER_BITS-1)-1 (weakly not-taken; 01 for the default) and increments the pointer.
  - After the edge that writes entry DEPTH-1 -> RUN.
  - ready_out is registered, =1 exactly when state==RUN, so it goes high after DEPTH edges following reset release.
  - feedback_enable_in is ignored in INIT (no table write, no error).
- FSM RUN: stays in RUN until reset.
- Decode (combinational):
  - is_branch = ins_data_in[6:0]==7'b1100011.
  - is_jal = ins_data_in[6:0]==7'b1101111.
  - B-imm = sign-extend {ins[31],ins[7],ins[30:25],ins[11:8],0}.
  - J-imm = sign-extend {ins[31],ins[19:12],ins[20],ins[30:21],0}.
- Prediction (combinational from the current table read, valid only when ready_out=1):
  - taken_pred_out = is_jal | (is_branch & entry[index][MSB]).
  - pc_branch_sel_out = ready_out & taken_pred_out.
  - pred_pc_out = pc_addr_in + imm (B or J) when pc_branch_sel_out, else pc_addr_in + 4. Both sums are modulo 2**32 and wrap silently.
  - When ready_out=0: taken_pred_out=0, pc_branch_sel_out=0, pred_pc_out=pc_addr_in+4.
  - pred_index_out = pc_addr_in[INDEX_BITS+1:2] always.
- Training (RUN, feedback_enable_in=1, at the rising edge):
  - Taken: entry[feedback_index_in] increments, saturating at 2**COUNTER_BITS-1.
  - Not taken: decrements, saturating at 0.
  - One update per cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value; the new value is visible from the next cycle.
- JAL never trains the table. Non-control instructions are never predicted taken.
- Reset outputs: ready_out=0, taken_pred_out=0, pc_branch_sel_out=0, pred_pc_out=pc_addr_in+4, pred_index_out=pc index.

Test Plan:
1. Init: release reset with defaults; ready_out must stay 0 for 1023 edges and go 1 after edge 1024. Then branch ins 0x00000463 (beq x0,x0,+8) at PC 0x100 -> taken_pred_out=0, pred_pc_out=0x104.
2. Training: RUN, 2 feedbacks taken on index 0x40 (PC 0x100) -> beq at PC 0x100 predicts taken, pred_pc_out=0x108, sel=1. A third taken feedback saturates at 3; then 2 not-taken -> counter 1, predicts not taken.
3. Immediates: JAL 0xFF9FF06F (jal x0,-8) at PC 0x10 -> sel=1 and pred_pc_out=0x8, with no table change. Backward branch imm -4 at PC 0x0 with counter trained taken -> pred_pc_out=0xFFFFFFFC (wrap).
4. Saturation and collision: 5 not-taken feedbacks on a fresh entry -> stays 0. Feedback and lookup on the same index in the same cycle -> old prediction that cycle, new prediction next cycle.
5. Reset mid-operation: assert reset_n_in during INIT at pointer 500 and again in RUN -> ready_out drops immediately (asynchronous) and a full 1024-edge re-init occurs. Feedback during INIT is ignored: after init, the entry reads 01.
6. Parametrisation: INDEX_BITS=4, COUNTER_BITS=3 -> ready_out after 16 edges, init value 3. 4 taken feedbacks take it to 7 and it saturates there; PCs 0x0 and 0x40 alias to index 0.
